// File: rtl/axi_slave_mem.sv
// axi_slave_mem
//   AXI-style memory slave terminating the write (AW/W/B) and read (AR/R)
//   channels of an upstream master. Holds MEM_DEPTH 32-bit words. The write
//   and read channels are independent FSMs, so a write burst and a read burst
//   may be in flight at the same time. INCR bursts only, 4-byte beats.
//
//   Parameters
//     MEM_DEPTH  number of 32-bit words (power of 2); byte space MEM_DEPTH*4
//     RD_LEN     beats per read burst minus 1; driven on RLEN_o
//     ID_W       width of the ID fields
//
//   Ports
//     ACLK_i, ARESETn_i                 clock (rising edge), async active-low reset
//     AWADDR_i/AWVALID_i/AWID_i         write address channel in
//     AWREADY_o                         write address accepted
//     WDATA_i/WVALID_i/WLEN_i/WSIZE_i/WLAST_i   write data channel in
//     WREADY_o                          write beat accepted
//     BVALID_o/BRESP_o/BID_o, BREADY_i  write response channel
//     ARADDR_i/ARVALID_i/ARID_i         read address channel in
//     ARREADY_o                         read address accepted
//     RDATA_o/RVALID_o/RRESP_o/RID_o/RLEN_o/RSIZE_o/RLAST_o, RREADY_i
//                                       read data channel
//
//   Response codes: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR (start address
//   beyond the memory). All outputs are registered.

module axi_slave_mem #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned RD_LEN    = 3,
  parameter int unsigned ID_W      = 4
) (
  input  logic            ACLK_i,
  input  logic            ARESETn_i,
  // write address
  input  logic [31:0]     AWADDR_i,
  input  logic            AWVALID_i,
  input  logic [ID_W-1:0] AWID_i,
  output logic            AWREADY_o,
  // write data
  input  logic [31:0]     WDATA_i,
  input  logic            WVALID_i,
  input  logic [3:0]      WLEN_i,
  input  logic [2:0]      WSIZE_i,
  input  logic            WLAST_i,
  output logic            WREADY_o,
  // write response
  output logic            BVALID_o,
  output logic [1:0]      BRESP_o,
  output logic [ID_W-1:0] BID_o,
  input  logic            BREADY_i,
  // read address
  input  logic [31:0]     ARADDR_i,
  input  logic            ARVALID_i,
  input  logic [ID_W-1:0] ARID_i,
  output logic            ARREADY_o,
  // read data
  output logic [31:0]     RDATA_o,
  output logic            RVALID_o,
  output logic [1:0]      RRESP_o,
  output logic [ID_W-1:0] RID_o,
  output logic [3:0]      RLEN_o,
  output logic [2:0]      RSIZE_o,
  output logic            RLAST_o,
  input  logic            RREADY_i
);

  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [32:0] BYTE_SPAN = 33'(MEM_DEPTH) << 2;
  localparam logic [2:0]  SIZE_4B   = 3'b010;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLV  = 2'b10;
  localparam logic [1:0]  RESP_DEC  = 2'b11;

  logic [31:0] mem [MEM_DEPTH];

  // Byte-offset bits of the addresses carry no information for 4-byte beats.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR_i[1:0], ARADDR_i[1:0]};

  assign RLEN_o  = 4'(RD_LEN);
  assign RSIZE_o = SIZE_4B;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t         w_state, w_state_nx;
  logic [IDX_W-1:0] w_idx, w_idx_nx;
  logic [3:0]       w_cnt, w_cnt_nx;
  logic [3:0]       w_len, w_len_nx;
  logic             w_oor, w_oor_nx;
  logic             w_size_err, w_size_err_nx;
  logic             w_cnt_err, w_cnt_err_nx;
  logic             awready_q, awready_nx;
  logic             wready_q, wready_nx;
  logic             bvalid_q, bvalid_nx;
  logic [1:0]       bresp_q, bresp_nx;
  logic [ID_W-1:0]  bid_q, bid_nx;

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [31:0]      mem_wdata;

  logic             aw_fire, w_fire, b_fire;
  logic [3:0]       len_now;
  logic             size_err_all, cnt_err_all;

  assign aw_fire = AWVALID_i && awready_q;
  assign w_fire  = WVALID_i && wready_q;
  assign b_fire  = bvalid_q && BREADY_i;

  always_comb begin
    w_state_nx    = w_state;
    w_idx_nx      = w_idx;
    w_cnt_nx      = w_cnt;
    w_len_nx      = w_len;
    w_oor_nx      = w_oor;
    w_size_err_nx = w_size_err;
    w_cnt_err_nx  = w_cnt_err;
    awready_nx    = awready_q;
    wready_nx     = wready_q;
    bvalid_nx     = bvalid_q;
    bresp_nx      = bresp_q;
    bid_nx        = bid_q;
    mem_we        = 1'b0;
    mem_waddr     = w_idx;
    mem_wdata     = WDATA_i;
    // WLEN is only meaningful on the first beat; later beats use the latched copy.
    len_now       = (w_cnt == 4'd0) ? WLEN_i : w_len;
    size_err_all  = w_size_err || (WSIZE_i != SIZE_4B);
    // A non-final beat at or past the declared length already makes the count wrong.
    cnt_err_all   = w_cnt_err || (WLAST_i ? (w_cnt != len_now) : (w_cnt >= len_now));

    case (w_state)
      W_IDLE: begin
        awready_nx = 1'b1;
        if (aw_fire) begin
          awready_nx    = 1'b0;
          wready_nx     = 1'b1;
          w_idx_nx      = AWADDR_i[2 +: IDX_W];
          w_oor_nx      = ({1'b0, AWADDR_i} >= BYTE_SPAN);
          bid_nx        = AWID_i;
          w_cnt_nx      = '0;
          w_size_err_nx = 1'b0;
          w_cnt_err_nx  = 1'b0;
          w_state_nx    = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          if (w_cnt == 4'd0) w_len_nx = WLEN_i;
          mem_we        = !w_oor && !size_err_all;
          w_idx_nx      = w_idx + IDX_W'(1);
          w_cnt_nx      = w_cnt + 4'd1;
          w_size_err_nx = size_err_all;
          w_cnt_err_nx  = cnt_err_all;
          if (WLAST_i) begin
            wready_nx  = 1'b0;
            bvalid_nx  = 1'b1;
            bresp_nx   = w_oor ? RESP_DEC :
                         (size_err_all || cnt_err_all) ? RESP_SLV : RESP_OKAY;
            w_state_nx = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (b_fire) begin
          bvalid_nx  = 1'b0;
          awready_nx = 1'b1;
          w_state_nx = W_IDLE;
        end
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      w_state    <= W_IDLE;
      w_idx      <= '0;
      w_cnt      <= '0;
      w_len      <= '0;
      w_oor      <= 1'b0;
      w_size_err <= 1'b0;
      w_cnt_err  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bid_q      <= '0;
    end else begin
      w_state    <= w_state_nx;
      w_idx      <= w_idx_nx;
      w_cnt      <= w_cnt_nx;
      w_len      <= w_len_nx;
      w_oor      <= w_oor_nx;
      w_size_err <= w_size_err_nx;
      w_cnt_err  <= w_cnt_err_nx;
      awready_q  <= awready_nx;
      wready_q   <= wready_nx;
      bvalid_q   <= bvalid_nx;
      bresp_q    <= bresp_nx;
      bid_q      <= bid_nx;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge ACLK_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign AWREADY_o = awready_q;
  assign WREADY_o  = wready_q;
  assign BVALID_o  = bvalid_q;
  assign BRESP_o   = bresp_q;
  assign BID_o     = bid_q;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t         r_state, r_state_nx;
  logic [IDX_W-1:0] r_idx, r_idx_nx;
  logic [3:0]       r_cnt, r_cnt_nx;
  logic             r_oor, r_oor_nx;
  logic             arready_q, arready_nx;
  logic             rvalid_q, rvalid_nx;
  logic [31:0]      rdata_q, rdata_nx;
  logic [1:0]       rresp_q, rresp_nx;
  logic [ID_W-1:0]  rid_q, rid_nx;
  logic             rlast_q, rlast_nx;

  logic             ar_fire, r_fire, ar_oor;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;

  assign ar_fire = ARVALID_i && arready_q;
  assign r_fire  = rvalid_q && RREADY_i;
  assign ar_oor  = ({1'b0, ARADDR_i} >= BYTE_SPAN);

  // The word for the next beat is fetched on the handshake edge itself, which is
  // why a write landing on the same edge is not visible (old data is returned).
  assign rd_idx  = (r_state == R_IDLE) ? ARADDR_i[2 +: IDX_W] : r_idx;
  assign rd_word = mem[rd_idx];

  always_comb begin
    r_state_nx = r_state;
    r_idx_nx   = r_idx;
    r_cnt_nx   = r_cnt;
    r_oor_nx   = r_oor;
    arready_nx = arready_q;
    rvalid_nx  = rvalid_q;
    rdata_nx   = rdata_q;
    rresp_nx   = rresp_q;
    rid_nx     = rid_q;
    rlast_nx   = rlast_q;

    case (r_state)
      R_IDLE: begin
        arready_nx = 1'b1;
        if (ar_fire) begin
          arready_nx = 1'b0;
          rvalid_nx  = 1'b1;
          rid_nx     = ARID_i;
          r_oor_nx   = ar_oor;
          rdata_nx   = ar_oor ? '0 : rd_word;
          rresp_nx   = ar_oor ? RESP_DEC : RESP_OKAY;
          rlast_nx   = (RD_LEN == 0);
          r_idx_nx   = rd_idx + IDX_W'(1);
          r_cnt_nx   = '0;
          r_state_nx = R_DATA;
        end
      end
      R_DATA: begin
        if (r_fire) begin
          if (rlast_q) begin
            rvalid_nx  = 1'b0;
            rlast_nx   = 1'b0;
            arready_nx = 1'b1;
            r_state_nx = R_IDLE;
          end else begin
            rdata_nx = r_oor ? '0 : rd_word;
            r_idx_nx = r_idx + IDX_W'(1);
            r_cnt_nx = r_cnt + 4'd1;
            rlast_nx = ((r_cnt + 4'd1) == 4'(RD_LEN));
          end
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_state   <= R_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_oor     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state   <= r_state_nx;
      r_idx     <= r_idx_nx;
      r_cnt     <= r_cnt_nx;
      r_oor     <= r_oor_nx;
      arready_q <= arready_nx;
      rvalid_q  <= rvalid_nx;
      rdata_q   <= rdata_nx;
      rresp_q   <= rresp_nx;
      rid_q     <= rid_nx;
      rlast_q   <= rlast_nx;
    end
  end

  assign ARREADY_o = arready_q;
  assign RVALID_o  = rvalid_q;
  assign RDATA_o   = rdata_q;
  assign RRESP_o   = rresp_q;
  assign RID_o     = rid_q;
  assign RLAST_o   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Testbench for axi_slave_mem: table-driven write and read bursts plus
// hand-written sequences for concurrency/same-word collision and mid-burst reset.

module tb_axi_slave_mem;

  localparam int ID_W = 4;

  logic            ACLK_i = 1'b0;
  logic            ARESETn_i = 1'b1;
  logic [31:0]     AWADDR_i = '0;
  logic            AWVALID_i = 1'b0;
  logic [ID_W-1:0] AWID_i = '0;
  logic            AWREADY_o;
  logic [31:0]     WDATA_i = '0;
  logic            WVALID_i = 1'b0;
  logic [3:0]      WLEN_i = '0;
  logic [2:0]      WSIZE_i = '0;
  logic            WLAST_i = 1'b0;
  logic            WREADY_o;
  logic            BVALID_o;
  logic [1:0]      BRESP_o;
  logic [ID_W-1:0] BID_o;
  logic            BREADY_i = 1'b0;
  logic [31:0]     ARADDR_i = '0;
  logic            ARVALID_i = 1'b0;
  logic [ID_W-1:0] ARID_i = '0;
  logic            ARREADY_o;
  logic [31:0]     RDATA_o;
  logic            RVALID_o;
  logic [1:0]      RRESP_o;
  logic [ID_W-1:0] RID_o;
  logic [3:0]      RLEN_o;
  logic [2:0]      RSIZE_o;
  logic            RLAST_o;
  logic            RREADY_i = 1'b0;

  always #5 ACLK_i = ~ACLK_i;

  axi_slave_mem #(.MEM_DEPTH(256), .RD_LEN(3), .ID_W(ID_W)) dut (
    .ACLK_i(ACLK_i), .ARESETn_i(ARESETn_i),
    .AWADDR_i(AWADDR_i), .AWVALID_i(AWVALID_i), .AWID_i(AWID_i), .AWREADY_o(AWREADY_o),
    .WDATA_i(WDATA_i), .WVALID_i(WVALID_i), .WLEN_i(WLEN_i), .WSIZE_i(WSIZE_i),
    .WLAST_i(WLAST_i), .WREADY_o(WREADY_o),
    .BVALID_o(BVALID_o), .BRESP_o(BRESP_o), .BID_o(BID_o), .BREADY_i(BREADY_i),
    .ARADDR_i(ARADDR_i), .ARVALID_i(ARVALID_i), .ARID_i(ARID_i), .ARREADY_o(ARREADY_o),
    .RDATA_o(RDATA_o), .RVALID_o(RVALID_o), .RRESP_o(RRESP_o), .RID_o(RID_o),
    .RLEN_o(RLEN_o), .RSIZE_o(RSIZE_o), .RLAST_o(RLAST_o), .RREADY_i(RREADY_i)
  );

  typedef struct {
    logic [31:0]     addr;
    logic [ID_W-1:0] id;
    logic [3:0]      wlen;
    logic [2:0]      wsize;
    int              nbeats;
    logic [31:0]     base;
    logic [1:0]      exp_resp;
    int              nwr;     // leading beats expected to land in memory
    int              bhold;   // cycles BREADY stays low with BVALID up
  } wvec_t;

  typedef struct {
    logic [31:0]     addr;
    logic [ID_W-1:0] id;
    logic            oor;
    logic            stall;   // drop RREADY for one cycle on even beats
  } rvec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK_i);
    @(negedge ACLK_i);
  endtask

  task automatic aw_handshake(input logic [31:0] addr, input logic [ID_W-1:0] id);
    int n = 0;
    AWADDR_i = addr; AWID_i = id; AWVALID_i = 1'b1;
    while (!AWREADY_o && n < 20) begin @(negedge ACLK_i); n++; end
    check("awready_seen", 32'(AWREADY_o), 32'd1);
    tick();
    AWVALID_i = 1'b0;
  endtask

  task automatic w_beats(input wvec_t v, input int count);
    int n;
    for (int i = 0; i < count; i++) begin
      WVALID_i = 1'b1; WDATA_i = v.base + 32'(i); WLAST_i = (i == v.nbeats - 1);
      WLEN_i = v.wlen; WSIZE_i = v.wsize;
      n = 0;
      while (!WREADY_o && n < 20) begin @(negedge ACLK_i); n++; end
      check("wready_seen", 32'(WREADY_o), 32'd1);
      tick();
    end
    WVALID_i = 1'b0; WLAST_i = 1'b0;
  endtask

  task automatic do_write(input wvec_t v);
    aw_handshake(v.addr, v.id);
    w_beats(v, v.nbeats);
    check("b_latency", 32'(BVALID_o), 32'd1);
    check("wready_off", 32'(WREADY_o), 32'd0);
    check("bresp", 32'(BRESP_o), 32'(v.exp_resp));
    check("bid", 32'(BID_o), 32'(v.id));
    for (int c = 0; c < v.bhold; c++) begin
      tick();
      check("bvalid_hold", 32'(BVALID_o), 32'd1);
      check("bresp_hold", 32'(BRESP_o), 32'(v.exp_resp));
      check("bid_hold", 32'(BID_o), 32'(v.id));
    end
    BREADY_i = 1'b1;
    tick();
    BREADY_i = 1'b0;
    check("bvalid_drop", 32'(BVALID_o), 32'd0);
    check("awready_back", 32'(AWREADY_o), 32'd1);
    for (int i = 0; i < v.nwr; i++) model[(int'(v.addr[9:2]) + i) % 256] = v.base + 32'(i);
  endtask

  task automatic do_read(input rvec_t v);
    int n = 0;
    logic [31:0] exp;
    ARADDR_i = v.addr; ARID_i = v.id; ARVALID_i = 1'b1;
    while (!ARREADY_o && n < 20) begin @(negedge ACLK_i); n++; end
    check("arready_seen", 32'(ARREADY_o), 32'd1);
    tick();
    ARVALID_i = 1'b0; RREADY_i = 1'b1;
    check("r_latency", 32'(RVALID_o), 32'd1);
    for (int b = 0; b < 4; b++) begin
      exp = v.oor ? 32'd0 : model[(int'(v.addr[9:2]) + b) % 256];
      check("rvalid", 32'(RVALID_o), 32'd1);
      check("rdata", RDATA_o, exp);
      check("rid", 32'(RID_o), 32'(v.id));
      check("rresp", 32'(RRESP_o), v.oor ? 32'd3 : 32'd0);
      check("rlast", 32'(RLAST_o), (b == 3) ? 32'd1 : 32'd0);
      if (v.stall && (b % 2 == 0)) begin
        RREADY_i = 1'b0;
        tick();
        check("rvalid_stall", 32'(RVALID_o), 32'd1);
        check("rdata_stall", RDATA_o, exp);
        check("rlast_stall", 32'(RLAST_o), 32'd0);
        check("rid_stall", 32'(RID_o), 32'(v.id));
        RREADY_i = 1'b1;
      end
      tick();
    end
    RREADY_i = 1'b0;
    check("rvalid_drop", 32'(RVALID_o), 32'd0);
    check("arready_back", 32'(ARREADY_o), 32'd1);
  endtask

  wvec_t wtab [7];
  rvec_t rtab [5];

  initial begin
    wvec_t wv;
    //           addr     id    wlen  wsize nb  base           resp   nwr bhold
    wtab[0] = '{32'h010, 4'd4, 4'd3, 3'd2, 4, 32'hA000_0000, 2'b00, 4, 0};
    wtab[1] = '{32'h3F8, 4'd1, 4'd3, 3'd2, 4, 32'hB000_0000, 2'b00, 4, 0};  // 254,255,0,1
    wtab[2] = '{32'h400, 4'd3, 4'd3, 3'd2, 4, 32'hE000_0000, 2'b11, 0, 0};
    wtab[3] = '{32'h040, 4'd5, 4'd3, 3'd2, 4, 32'hC000_0000, 2'b00, 4, 0};
    wtab[4] = '{32'h040, 4'd6, 4'd3, 3'd0, 4, 32'hD000_0000, 2'b10, 0, 5};
    wtab[5] = '{32'h083, 4'd7, 4'd3, 3'd2, 4, 32'h5000_0000, 2'b00, 4, 0};  // words 32..35
    wtab[6] = '{32'h080, 4'd8, 4'd3, 3'd2, 2, 32'h6000_0000, 2'b10, 2, 0};  // WLAST on beat 1
    //           addr     id     oor   stall
    rtab[0] = '{32'h010, 4'd2, 1'b0, 1'b1};
    rtab[1] = '{32'h3F8, 4'd9, 1'b0, 1'b0};
    rtab[2] = '{32'h400, 4'd3, 1'b1, 1'b0};
    rtab[3] = '{32'h040, 4'd5, 1'b0, 1'b1};
    rtab[4] = '{32'h080, 4'hF, 1'b0, 1'b0};

    // Reset state
    ARESETn_i = 1'b0;
    @(negedge ACLK_i);
    @(negedge ACLK_i);
    check("rst_awready", 32'(AWREADY_o), 32'd0);
    check("rst_wready", 32'(WREADY_o), 32'd0);
    check("rst_bvalid", 32'(BVALID_o), 32'd0);
    check("rst_bresp", 32'(BRESP_o), 32'd0);
    check("rst_bid", 32'(BID_o), 32'd0);
    check("rst_arready", 32'(ARREADY_o), 32'd0);
    check("rst_rvalid", 32'(RVALID_o), 32'd0);
    check("rst_rdata", RDATA_o, 32'd0);
    check("rst_rresp", 32'(RRESP_o), 32'd0);
    check("rst_rid", 32'(RID_o), 32'd0);
    check("rst_rlast", 32'(RLAST_o), 32'd0);
    check("rlen_const", 32'(RLEN_o), 32'd3);
    check("rsize_const", 32'(RSIZE_o), 32'd2);
    ARESETn_i = 1'b1;
    check("awready_at_release", 32'(AWREADY_o), 32'd0);
    tick();
    check("awready_after_release", 32'(AWREADY_o), 32'd1);
    check("arready_after_release", 32'(ARREADY_o), 32'd1);

    for (int i = 0; i < 7; i++) do_write(wtab[i]);
    for (int i = 0; i < 5; i++) do_read(rtab[i]);

    // Concurrent AW+AR in one cycle; write to word 0 lands on the edge that fetches word 0
    AWADDR_i = 32'h0; AWID_i = 4'd11; AWVALID_i = 1'b1;
    ARADDR_i = 32'h3F8; ARID_i = 4'd12; ARVALID_i = 1'b1;
    check("cc_awready", 32'(AWREADY_o), 32'd1);
    check("cc_arready", 32'(ARREADY_o), 32'd1);
    tick();
    AWVALID_i = 1'b0; ARVALID_i = 1'b0; RREADY_i = 1'b1;
    check("cc_wready", 32'(WREADY_o), 32'd1);
    check("cc_rvalid", 32'(RVALID_o), 32'd1);
    check("cc_beat0", RDATA_o, 32'hB000_0000);
    tick();
    check("cc_beat1", RDATA_o, 32'hB000_0001);
    WVALID_i = 1'b1; WDATA_i = 32'hF00D_0000; WLAST_i = 1'b1; WLEN_i = 4'd0; WSIZE_i = 3'd2;
    tick();
    WVALID_i = 1'b0; WLAST_i = 1'b0;
    check("cc_beat2_old", RDATA_o, 32'hB000_0002);
    check("cc_bvalid", 32'(BVALID_o), 32'd1);
    check("cc_bresp", 32'(BRESP_o), 32'd0);
    check("cc_bid", 32'(BID_o), 32'd11);
    tick();
    check("cc_beat3", RDATA_o, 32'hB000_0003);
    check("cc_rlast", 32'(RLAST_o), 32'd1);
    tick();
    RREADY_i = 1'b0;
    check("cc_rvalid_drop", 32'(RVALID_o), 32'd0);
    BREADY_i = 1'b1;
    tick();
    BREADY_i = 1'b0;
    model[0] = 32'hF00D_0000;
    do_read('{32'h3F8, 4'd12, 1'b0, 1'b0});

    // Reset in the middle of a burst: two beats written, no response afterwards
    wv = '{32'h100, 4'd10, 4'd3, 3'd2, 4, 32'h7000_0000, 2'b00, 0, 0};
    aw_handshake(wv.addr, wv.id);
    w_beats(wv, 2);
    ARESETn_i = 1'b0;
    #1;
    check("mid_rst_awready", 32'(AWREADY_o), 32'd0);
    check("mid_rst_wready", 32'(WREADY_o), 32'd0);
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;
    tick();
    check("mid_rst_awready_back", 32'(AWREADY_o), 32'd1);
    for (int c = 0; c < 3; c++) begin
      check("mid_rst_no_b", 32'(BVALID_o), 32'd0);
      tick();
    end
    model[64] = 32'h7000_0000;
    model[65] = 32'h7000_0001;
    do_write('{32'h108, 4'd13, 4'd1, 3'd2, 2, 32'h8000_0000, 2'b00, 2, 0});
    do_read('{32'h100, 4'd14, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequences are short; anything longer is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
